// File: rtl/qracc_sram_ctrl.sv
// Round-robin multi-port front-end sequencing precharge/wordline/write/sense for the QRAcc SRAM macro.
// Latency: write turnaround pchCycles+2, read data valid pchCycles+saCycles+2 cycles after the handshake.
// Backpressure: rq_ready_o is raised only in IDLE for the granted port; requesters hold their request until ready.
module qracc_sram_ctrl #(
    parameter int numRows   = 128,
    parameter int numCols   = 32,
    parameter int numPorts  = 2,
    parameter int pchCycles = 1,
    parameter int saCycles  = 1,
    localparam int addrBits = $clog2(numRows)
) (
    input  logic                         clk,
    input  logic                         nrst,
    input  logic [numPorts-1:0]          rq_valid_i,
    input  logic [numPorts-1:0]          rq_wr_i,
    input  logic [numPorts*addrBits-1:0] addr_i,
    input  logic [numPorts*numCols-1:0]  wr_data_i,
    input  logic [numPorts*numCols-1:0]  wr_mask_i,
    output logic [numPorts-1:0]          rq_ready_o,
    output logic [numPorts-1:0]          rd_valid_o,
    output logic [numCols-1:0]           rd_data_o,
    output logic                         err_o,
    output logic                         busy_o,
    output logic [numRows-1:0]           wl_o,
    output logic                         pch_o,
    output logic                         write_o,
    output logic [numCols-1:0]           wr_data_o,
    output logic [numCols-1:0]           csel_o,
    output logic                         saen_o,
    input  logic [numCols-1:0]           sa_out_i
);

    localparam int idBits  = (numPorts > 1) ? $clog2(numPorts) : 1;
    localparam int maxCyc  = (pchCycles > saCycles) ? pchCycles : saCycles;
    localparam int cntBits = (maxCyc > 1) ? $clog2(maxCyc) : 1;

    typedef enum logic [1:0] {IDLE, PCH, WL, SENSE} state_t;

    state_t              state;
    logic [idBits-1:0]   last_grant;
    logic [idBits-1:0]   lat_id;
    logic [idBits-1:0]   gnt_id;
    logic                gnt_vld;
    logic                hs;
    logic [addrBits-1:0] lat_addr;
    logic                lat_wr;
    logic [numCols-1:0]  lat_data;
    logic [numCols-1:0]  lat_mask;
    logic [cntBits-1:0]  cnt;
    logic                in_range;

    // A power-of-two row count makes every address legal.
    generate
        if (numRows == (1 << addrBits)) begin : g_full_rows
            assign in_range = 1'b1;
        end else begin : g_part_rows
            assign in_range = (32'(lat_addr) < numRows);
        end
    endgenerate

    always_comb begin
        int idx;
        idx     = 0;
        gnt_vld = 1'b0;
        gnt_id  = '0;
        for (int i = 1; i <= numPorts; i++) begin
            idx = (int'(last_grant) + i) % numPorts;
            if (!gnt_vld && rq_valid_i[idx]) begin
                gnt_vld = 1'b1;
                gnt_id  = idBits'(idx);
            end
        end
    end

    assign hs         = (state == IDLE) && gnt_vld;
    assign rq_ready_o = hs ? (numPorts'(1) << gnt_id) : '0;
    assign busy_o     = (state != IDLE);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state      <= IDLE;
            last_grant <= idBits'(numPorts - 1);
            lat_id     <= '0;
            lat_addr   <= '0;
            lat_wr     <= 1'b0;
            lat_data   <= '0;
            lat_mask   <= '0;
            cnt        <= '0;
            rd_data_o  <= '0;
            rd_valid_o <= '0;
            err_o      <= 1'b0;
        end else begin
            rd_valid_o <= '0;
            err_o      <= 1'b0;
            case (state)
                IDLE: begin
                    if (hs) begin
                        state      <= PCH;
                        last_grant <= gnt_id;
                        lat_id     <= gnt_id;
                        lat_addr   <= addr_i[int'(gnt_id)*addrBits +: addrBits];
                        lat_wr     <= rq_wr_i[gnt_id];
                        lat_data   <= wr_data_i[int'(gnt_id)*numCols +: numCols];
                        lat_mask   <= wr_mask_i[int'(gnt_id)*numCols +: numCols];
                        cnt        <= cntBits'(pchCycles - 1);
                    end
                end
                PCH: begin
                    if (cnt == '0) state <= WL;
                    else           cnt   <= cnt - 1'b1;
                end
                WL: begin
                    err_o <= !in_range;
                    if (lat_wr) begin
                        state <= IDLE;
                    end else begin
                        state <= SENSE;
                        cnt   <= cntBits'(saCycles - 1);
                    end
                end
                SENSE: begin
                    if (cnt == '0) begin
                        state      <= IDLE;
                        rd_data_o  <= in_range ? sa_out_i : '0;
                        rd_valid_o <= numPorts'(1) << lat_id;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Analog controls are pure state decodes so reset kills them without waiting for a clock.
    always_comb begin
        wl_o      = '0;
        pch_o     = 1'b0;
        write_o   = 1'b0;
        wr_data_o = '0;
        csel_o    = '0;
        saen_o    = 1'b0;
        case (state)
            PCH: pch_o = 1'b1;
            WL: begin
                if (in_range) wl_o = numRows'(1) << lat_addr;
                if (lat_wr) begin
                    write_o   = 1'b1;
                    wr_data_o = lat_data;
                    csel_o    = lat_mask;
                end else begin
                    csel_o = '1;
                end
            end
            SENSE: begin
                if (in_range) wl_o = numRows'(1) << lat_addr;
                saen_o = 1'b1;
                csel_o = '1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_qracc_sram_ctrl.sv
// Directed bench: instance A (100 rows, P=S=1) with an SRAM array model, instance B (128 rows, P=3, S=2).
module tb_qracc_sram_ctrl;

    localparam int ROWS_A = 100;
    localparam int ROWS_B = 128;

    logic clk = 1'b0;
    logic nrst;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [1:0]        rq_valid_a, rq_wr_a, rq_ready_a, rd_valid_a;
    logic [13:0]       addr_a;
    logic [63:0]       wr_data_a, wr_mask_a;
    logic [31:0]       rd_data_a, wr_data_o_a, csel_a, sa_out_a;
    logic              err_a, busy_a, pch_a, write_a, saen_a;
    logic [ROWS_A-1:0] wl_a;

    logic [1:0]        rq_valid_b, rq_wr_b, rq_ready_b, rd_valid_b;
    logic [13:0]       addr_b;
    logic [63:0]       wr_data_b, wr_mask_b;
    logic [31:0]       rd_data_b, wr_data_o_b, csel_b, sa_out_b;
    logic              err_b, busy_b, pch_b, write_b, saen_b;
    logic [ROWS_B-1:0] wl_b;

    qracc_sram_ctrl #(.numRows(ROWS_A), .numCols(32), .numPorts(2), .pchCycles(1), .saCycles(1)) dut_a (
        .clk(clk), .nrst(nrst), .rq_valid_i(rq_valid_a), .rq_wr_i(rq_wr_a), .addr_i(addr_a),
        .wr_data_i(wr_data_a), .wr_mask_i(wr_mask_a), .rq_ready_o(rq_ready_a), .rd_valid_o(rd_valid_a),
        .rd_data_o(rd_data_a), .err_o(err_a), .busy_o(busy_a), .wl_o(wl_a), .pch_o(pch_a),
        .write_o(write_a), .wr_data_o(wr_data_o_a), .csel_o(csel_a), .saen_o(saen_a), .sa_out_i(sa_out_a)
    );

    qracc_sram_ctrl #(.numRows(ROWS_B), .numCols(32), .numPorts(2), .pchCycles(3), .saCycles(2)) dut_b (
        .clk(clk), .nrst(nrst), .rq_valid_i(rq_valid_b), .rq_wr_i(rq_wr_b), .addr_i(addr_b),
        .wr_data_i(wr_data_b), .wr_mask_i(wr_mask_b), .rq_ready_o(rq_ready_b), .rd_valid_o(rd_valid_b),
        .rd_data_o(rd_data_b), .err_o(err_b), .busy_o(busy_b), .wl_o(wl_b), .pch_o(pch_b),
        .write_o(write_b), .wr_data_o(wr_data_o_b), .csel_o(csel_b), .saen_o(saen_b), .sa_out_i(sa_out_b)
    );

    // Array model for A: masked column writes, sense output floats high when no row is selected.
    logic [31:0] mem [ROWS_A];
    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int r = 0; r < ROWS_A; r++) mem[r] <= '0;
        end else if (write_a) begin
            for (int r = 0; r < ROWS_A; r++)
                if (wl_a[r]) mem[r] <= (mem[r] & ~csel_a) | (wr_data_o_a & csel_a);
        end
    end

    always_comb begin
        sa_out_a = '1;
        for (int r = 0; r < ROWS_A; r++)
            if (wl_a[r]) sa_out_a = mem[r];
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input int p, input logic wr, input logic [6:0] a,
                         input logic [31:0] d, input logic [31:0] m);
        rq_valid_a             = '0;
        rq_valid_a[p]          = 1'b1;
        rq_wr_a[p]             = wr;
        addr_a[p*7 +: 7]       = a;
        wr_data_a[p*32 +: 32]  = d;
        wr_mask_a[p*32 +: 32]  = m;
    endtask

    function automatic logic [127:0] wl_exp(input logic [6:0] a);
        return (a < 7'd100) ? (128'(1) << a) : 128'd0;
    endfunction

    task automatic write_req_a(input string tag, input int p, input logic [6:0] a,
                               input logic [31:0] d, input logic [31:0] m);
        set_a(p, 1'b1, a, d, m);
        #1;
        chk({tag, "_ready"}, rq_ready_a, 128'(1) << p);
        tick();
        rq_valid_a = '0;
        chk({tag, "_pch"}, pch_a, 1);
        chk({tag, "_ready_busy"}, rq_ready_a, 0);
        tick();
        chk({tag, "_wl"}, wl_a, wl_exp(a));
        chk({tag, "_write"}, write_a, 1);
        chk({tag, "_wrdata"}, wr_data_o_a, d);
        chk({tag, "_csel"}, csel_a, m);
        tick();
        chk({tag, "_busy_done"}, busy_a, 0);
        chk({tag, "_err"}, err_a, (a >= 7'd100));
        chk({tag, "_write_off"}, write_a, 0);
    endtask

    task automatic read_req_a(input string tag, input int p, input logic [6:0] a, input logic [31:0] exp);
        set_a(p, 1'b0, a, 32'h0, 32'h0);
        #1;
        chk({tag, "_ready"}, rq_ready_a, 128'(1) << p);
        tick();
        rq_valid_a = '0;
        chk({tag, "_pch_wl"}, wl_a, 0);
        tick();
        chk({tag, "_wl"}, wl_a, wl_exp(a));
        chk({tag, "_csel"}, csel_a, 32'hFFFF_FFFF);
        chk({tag, "_write"}, write_a, 0);
        tick();
        chk({tag, "_saen"}, saen_a, 1);
        chk({tag, "_wl_hold"}, wl_a, wl_exp(a));
        chk({tag, "_err"}, err_a, (a >= 7'd100));
        tick();
        chk({tag, "_rdvalid"}, rd_valid_a, 128'(1) << p);
        chk({tag, "_rddata"}, rd_data_a, exp);
        chk({tag, "_err_clear"}, err_a, 0);
        chk({tag, "_saen_off"}, saen_a, 0);
    endtask

    initial begin
        nrst       = 1'b0;
        rq_valid_a = '0; rq_wr_a = '0; addr_a = '0; wr_data_a = '0; wr_mask_a = '0;
        rq_valid_b = '0; rq_wr_b = '0; addr_b = '0; wr_data_b = '0; wr_mask_b = '0;
        sa_out_b   = 32'hCAFE_0123;
        #2;
        chk("rst_busy", busy_a, 0);
        chk("rst_wl", wl_a, 0);
        chk("rst_pch", pch_a, 0);
        chk("rst_csel", csel_a, 0);
        chk("rst_rddata", rd_data_a, 0);
        chk("rst_rdvalid", rd_valid_a, 0);
        chk("rst_err", err_a, 0);
        #10 nrst = 1'b1;
        tick();

        write_req_a("wr5", 0, 7'd5, 32'hA5A5_1234, 32'hFFFF_FFFF);
        read_req_a("rd5", 0, 7'd5, 32'hA5A5_1234);
        write_req_a("mwr5", 0, 7'd5, 32'h1111_2222, 32'h0000_FFFF);
        read_req_a("mrd5", 0, 7'd5, 32'hA5A5_2222);
        write_req_a("wr9", 1, 7'd9, 32'hDEAD_BEEF, 32'hFFFF_FFFF);

        // Both ports stay valid; each new grant lands in the previous read's rd_valid cycle.
        set_a(0, 1'b0, 7'd5, 32'h0, 32'h0);
        set_a(1, 1'b0, 7'd9, 32'h0, 32'h0);
        rq_valid_a = 2'b11;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("rr_grant", rq_ready_a, (k % 2 == 0) ? 2'b01 : 2'b10);
            repeat (4) tick();
            chk("rr_rdvalid", rd_valid_a, (k % 2 == 0) ? 2'b01 : 2'b10);
            chk("rr_rddata", rd_data_a, (k % 2 == 0) ? 32'hA5A5_2222 : 32'hDEAD_BEEF);
        end
        rq_valid_a = '0;
        tick();

        read_req_a("oor_rd", 0, 7'd120, 32'h0);
        write_req_a("oor_wr", 0, 7'd120, 32'h5555_AAAA, 32'hFFFF_FFFF);

        // Reset in the middle of SENSE.
        set_a(0, 1'b0, 7'd5, 32'h0, 32'h0);
        #1;
        tick();
        rq_valid_a = '0;
        tick();
        tick();
        chk("mid_saen_pre", saen_a, 1);
        #1 nrst = 1'b0;
        #1;
        chk("mid_saen", saen_a, 0);
        chk("mid_wl", wl_a, 0);
        chk("mid_csel", csel_a, 0);
        chk("mid_busy", busy_a, 0);
        #2 nrst = 1'b1;
        tick();
        chk("mid_no_rdvalid", rd_valid_a, 0);
        chk("mid_no_err", err_a, 0);
        set_a(1, 1'b0, 7'd9, 32'h0, 32'h0);
        set_a(0, 1'b0, 7'd5, 32'h0, 32'h0);
        rq_valid_a = 2'b11;
        #1;
        chk("mid_first_grant", rq_ready_a, 2'b01);
        tick();
        rq_valid_a = '0;
        repeat (3) tick();

        // Instance B: 3-cycle precharge, 2-cycle sense, top row.
        rq_valid_b     = 2'b01;
        addr_b[6:0]    = 7'd127;
        #1;
        chk("b_ready", rq_ready_b, 2'b01);
        tick();
        rq_valid_b = '0;
        for (int c = 1; c <= 7; c++) begin
            chk("b_pch", pch_b, (c <= 3));
            chk("b_saen", saen_b, (c == 5 || c == 6));
            chk("b_wl", wl_b, (c >= 4 && c <= 6) ? (128'(1) << 127) : 128'd0);
            chk("b_rdvalid", rd_valid_b, (c == 7) ? 2'b01 : 2'b00);
            if (c == 6) begin
                rq_valid_b = 2'b01;
                #1;
                chk("b_ready_sense", rq_ready_b, 0);
            end
            if (c < 7) tick();
        end
        chk("b_rddata", rd_data_b, 32'hCAFE_0123);
        chk("b_b2b_grant", rq_ready_b, 2'b01);
        tick();
        rq_valid_b = '0;
        sa_out_b   = 32'h1357_9BDF;
        repeat (6) tick();
        chk("b2_rdvalid", rd_valid_b, 2'b01);
        chk("b2_rddata", rd_data_b, 32'h1357_9BDF);
        chk("b_err", err_b, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/qracc_sram_ctrl.md
# qracc_sram_ctrl

Parametrised multi-port digital front-end for the QRAcc SRAM macro. It arbitrates up to numPorts request/ready ports with round-robin, then sequences the macro's precharge, wordline, write and sense-amp controls per access. Writes are masked per column, and read data returns on a per-port valid pulse. It sits between the QRAcc controller/loader masters and the analog array, which is driven through the WL/PCH/WRITE/CSEL/SAEN nets.

## Interface
- numRows, 128: SRAM rows; addrBits = $clog2(numRows).
- numCols, 32: SRAM columns, equal to the data word width.
- numPorts, 2: request ports, ≥1.
- pchCycles, 1: precharge duration in cycles, ≥1.
- saCycles, 1: sense duration in cycles, ≥1.
- clk  in  1  clock; all logic is on the rising edge.
- nrst  in  1  reset, asynchronous, active-low.
- rq_valid_i  in  numPorts  request valid, one bit per port.
- rq_wr_i  in  numPorts  1 = write, 0 = read.
- addr_i  in  numPorts*addrBits  row address; port p occupies slice [p*addrBits +: addrBits].
- wr_data_i  in  numPorts*numCols  write data, packed per port.
- wr_mask_i  in  numPorts*numCols  per-column write enable, packed per port.
- rq_ready_o  out  numPorts  request accepted when ready & valid.
- rd_valid_o  out  numPorts  one-cycle read-data-valid pulse.
- rd_data_o  out  numCols  read data; shared across ports.
- err_o  out  1  one-cycle pulse on an out-of-range address.
- busy_o  out  1  FSM is not in IDLE.
- wl_o  out  numRows  one-hot wordline.
- pch_o  out  1  bitline precharge.
- write_o  out  1  write drive enable.
- wr_data_o  out  numCols  bitline write data.
- csel_o  out  numCols  column select.
- saen_o  out  1  sense-amp enable.
- sa_out_i  in  numCols  sense-amp outputs.

## Operation
- **FSM states:** IDLE, PCH, WL, SENSE.
- **Arbitration:**
  - In IDLE, the arbiter grants the first valid port after lastGrant, in ascending order with wrap.
  - rq_ready_o is high only for the granted port and only in IDLE. All ready bits are 0 in other states.
  - The handshake latches the port's addr, wr, data, mask and id, updates lastGrant, and moves the FSM to PCH.
- **PCH:** pch_o=1 for pchCycles cycles (down-counter), then WL.
- **WL (1 cycle):**
  - wl_o = 1<<addr.
  - Write: write_o=1, wr_data_o=latched data, csel_o=latched mask, then IDLE.
  - Read: write_o=0, csel_o=all ones, then SENSE.
- **SENSE:**
  - wl_o stays held, saen_o=1 and csel_o=all ones for saCycles cycles.
  - sa_out_i is sampled on the last SENSE edge into rd_data_o, which holds until the next read capture.
  - The FSM then returns to IDLE.
- **Read return:** rd_valid_o[id] pulses in the first IDLE cycle after SENSE. A new grant may occur in that same cycle.
- **Out-of-range address (addr ≥ numRows):**
  - The request is accepted and sequenced normally, with wl_o=0 throughout.
  - A write has no effect.
  - A read returns rd_data_o=0 and still pulses rd_valid_o.
  - err_o pulses in the cycle the request exits WL.
- **Masked write:** a write with an all-zero mask still runs the full sequence with csel_o=0.
- **Inactive drive:** outside their states, wl_o, pch_o, write_o, saen_o, wr_data_o and csel_o are 0.
- **Reset state:** all outputs 0, rd_data_o=0, FSM=IDLE, lastGrant=numPorts-1 (port 0 has first priority), counters cleared.
- **Reset mid-operation:** any in-flight access is aborted with no rd_valid_o and no err_o pulse. All analog controls drop to 0 asynchronously.

## Timing
- Handshake edge = cycle 0.
- PCH occupies cycles 1..P (P = pchCycles); WL is cycle P+1.
- Write: ready may reassert in cycle P+2.
- Read: SENSE occupies cycles P+2..P+1+S (S = saCycles); rd_valid_o and rd_data_o are valid in cycle P+2+S.
- Defaults (P=S=1): write turnaround is 3 cycles, read latency is 4 cycles.
- All outputs are registered or decoded from FSM state, except rq_ready_o, which is combinational from rq_valid_i and lastGrant in IDLE.
- Requesters must hold valid, addr, wr, data and mask stable until ready.
- An outstanding valid is never dropped. A port that is continuously valid is granted within numPorts grants.

## Test plan
- **Reset:** assert nrst=0 mid-SENSE -> all outputs 0 immediately; FSM returns to IDLE; no rd_valid_o pulse; first post-reset grant goes to port 0.
- **Write then read:** port 0 writes addr 5, data 0xA5A5_1234, mask all ones -> wl_o=1<<5 in cycle 2 with write_o=1. Port 0 then reads addr 5 with a model driving sa_out_i=0xA5A5_1234 -> rd_valid_o[0] and rd_data_o=0xA5A5_1234 four cycles after the handshake.
- **Masked write:** mask 0x0000_FFFF -> csel_o=0x0000_FFFF during WL; model retains upper 16 bits.
- **Round-robin:** both ports valid continuously -> grants alternate 0,1,0,1; rd_valid_o only on the issuing port.
- **Out of range:** numRows=100, read addr 120 -> wl_o=0 throughout; err_o pulses; rd_data_o=0; rd_valid_o still pulses.
- **Parameter sweep:** pchCycles=3, saCycles=2 -> pch_o high for 3 cycles; read latency 7; back-to-back read grant in the rd_valid_o cycle.
